// File: rtl/jtag_debug_ocimem_access.sv
// jtag_debug_ocimem_access
//   Executes debug-memory commands from the JTAG debug-slave wrapper in the
//   system clock domain. Each command is a single-word read or write on a
//   debug RAM master port that uses a waitrequest/readdatavalid handshake.
//
//   State table:
//     IDLE    | accepting commands; nothing in flight
//     RD_REQ  | mem_read held until the slave drops waitrequest
//     RD_WAIT | read accepted, waiting for readdatavalid
//     WR_REQ  | mem_write held until the slave drops waitrequest
//
// Ports:
//   clk, reset                 system clock, async active-high reset
//   jdo                        command payload, valid in the pulse cycle
//   take_action_ocimem_a       address load (jdo[35]=1 also starts a read)
//   take_action_ocimem_b       write jdo[31:0] at the current address
//   take_no_action_ocimem_a    read at the current address
//   mem_addr/read/write/wdata  debug RAM master request
//   mem_waitrequest            slave stall
//   mem_readdata/readdatavalid read return
//   MonDReg                    last read data
//   monitor_ready              last command completed
//   monitor_error              sticky: timeout, overrun or dropped command
module jtag_debug_ocimem_access #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [31:0]       mem_wdata,
  input  logic              mem_waitrequest,
  input  logic [31:0]       mem_readdata,
  input  logic              mem_readdatavalid,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RD_REQ  = 2'd1;
  localparam logic [1:0] RD_WAIT = 2'd2;
  localparam logic [1:0] WR_REQ  = 2'd3;

  localparam logic [15:0]       TC_LAST  = 16'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  logic [1:0]        state;
  logic [ADDR_W-1:0] addr;
  logic [15:0]       tmo_cnt;
  logic              any_cmd;
  logic              drop_lower;
  logic              tmo_hit;
  logic              unused_jdo;

  assign unused_jdo = ^{jdo[37:36], jdo[34:32]};

  // Requests decode straight from state so an async reset drops them at once
  // and read/write can never be asserted together.
  assign mem_read  = (state == RD_REQ);
  assign mem_write = (state == WR_REQ);
  assign mem_addr  = addr;

  assign any_cmd = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;

  // A pulse loses arbitration if any higher-priority pulse shares its cycle.
  assign drop_lower = take_action_ocimem_a ?
                      (take_action_ocimem_b | take_no_action_ocimem_a) :
                      (take_action_ocimem_b & take_no_action_ocimem_a);

  // Counter value equals the number of cycles already spent in this state.
  assign tmo_hit = (tmo_cnt == TC_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      addr          <= '0;
      mem_wdata     <= '0;
      MonDReg       <= '0;
      monitor_ready <= 1'b0;
      monitor_error <= 1'b0;
      tmo_cnt       <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 16'd1;
      case (state)
        IDLE: begin
          tmo_cnt <= '0;
          if (take_action_ocimem_a) begin
            addr          <= jdo[ADDR_W-1:0];
            monitor_error <= drop_lower;
            if (jdo[35]) begin
              state         <= RD_REQ;
              monitor_ready <= 1'b0;
            end else begin
              monitor_ready <= 1'b1;
            end
          end else if (take_action_ocimem_b) begin
            mem_wdata     <= jdo[31:0];
            state         <= WR_REQ;
            monitor_ready <= 1'b0;
            if (drop_lower) monitor_error <= 1'b1;
          end else if (take_no_action_ocimem_a) begin
            state         <= RD_REQ;
            monitor_ready <= 1'b0;
          end
        end
        RD_REQ: begin
          if (!mem_waitrequest) begin
            tmo_cnt <= '0;
            if (mem_readdatavalid) begin
              MonDReg       <= mem_readdata;
              addr          <= addr + ADDR_ONE;
              state         <= IDLE;
              monitor_ready <= 1'b1;
            end else begin
              state <= RD_WAIT;
            end
          end else if (tmo_hit) begin
            state         <= IDLE;
            monitor_ready <= 1'b1;
            monitor_error <= 1'b1;
          end
        end
        RD_WAIT: begin
          if (mem_readdatavalid) begin
            MonDReg       <= mem_readdata;
            addr          <= addr + ADDR_ONE;
            state         <= IDLE;
            monitor_ready <= 1'b1;
          end else if (tmo_hit) begin
            state         <= IDLE;
            monitor_ready <= 1'b1;
            monitor_error <= 1'b1;
          end
        end
        WR_REQ: begin
          if (!mem_waitrequest) begin
            addr          <= addr + ADDR_ONE;
            state         <= IDLE;
            monitor_ready <= 1'b1;
          end else if (tmo_hit) begin
            state         <= IDLE;
            monitor_ready <= 1'b1;
            monitor_error <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
      // Commands arriving while busy are discarded; the transfer carries on.
      if ((state != IDLE) && any_cmd) monitor_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_jtag_debug_ocimem_access.sv
// tb_jtag_debug_ocimem_access
//   Directed bench with a behavioural debug-RAM slave. Expected transactions
//   are queued when a command is issued; writes are popped when the slave
//   accepts them, reads are popped when monitor_ready reports completion.
module tb_jtag_debug_ocimem_access;

  localparam int ADDR_W  = 8;
  localparam int TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [37:0] jdo;
  logic        take_action_ocimem_a;
  logic        take_action_ocimem_b;
  logic        take_no_action_ocimem_a;
  logic [7:0]  mem_addr;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_wdata;
  logic        mem_waitrequest = 1'b0;
  logic [31:0] mem_readdata = '0;
  logic        mem_readdatavalid = 1'b0;
  logic [31:0] MonDReg;
  logic        monitor_ready;
  logic        monitor_error;

  always #5 clk = ~clk;

  jtag_debug_ocimem_access #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .mem_addr                (mem_addr),
    .mem_read                (mem_read),
    .mem_write               (mem_write),
    .mem_wdata               (mem_wdata),
    .mem_waitrequest         (mem_waitrequest),
    .mem_readdata            (mem_readdata),
    .mem_readdatavalid       (mem_readdatavalid),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error)
  );

  typedef struct {
    bit          is_wr;
    logic [7:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t sb_e;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // slave model
  logic [31:0] sram    [256];
  logic [31:0] ref_mem [256];
  int          wait_cycles = 0;
  bit          stuck = 1'b0;
  int          rdv_delay = 1;
  bit          in_req = 1'b0;
  int          wait_left = 0;
  int          rdv_cnt = 0;
  logic [7:0]  rd_addr = '0;
  logic [7:0]  last_rd_addr = '0;
  logic [7:0]  held_addr = '0;
  logic [31:0] held_wdata = '0;
  int          wr_cycles = 0, rd_cycles = 0, wr_accepts = 0, rd_accepts = 0;
  int          unstable = 0, both_cnt = 0;

  always @(negedge clk) begin
    mem_readdatavalid = 1'b0;
    if (rdv_cnt > 0) begin
      rdv_cnt--;
      if (rdv_cnt == 0) begin
        mem_readdatavalid = 1'b1;
        mem_readdata      = sram[rd_addr];
      end
    end
    if (mem_read && mem_write) both_cnt++;
    if (mem_write) wr_cycles++;
    if (mem_read) rd_cycles++;
    if (mem_read || mem_write) begin
      if (!in_req) begin
        in_req     = 1'b1;
        wait_left  = wait_cycles;
        held_addr  = mem_addr;
        held_wdata = mem_wdata;
      end else if (mem_addr !== held_addr || (mem_write && mem_wdata !== held_wdata)) begin
        unstable++;
      end
      if (stuck || wait_left > 0) begin
        mem_waitrequest = 1'b1;
        if (!stuck) wait_left--;
      end else begin
        mem_waitrequest = 1'b0;
        in_req          = 1'b0;
        if (mem_write) begin
          wr_accepts++;
          sram[mem_addr] = mem_wdata;
          if (exp_q.size() == 0) chk("sb_wr_empty", 32'd0, 32'd1);
          else begin
            sb_e = exp_q.pop_front();
            chk("sb_wr_kind", 32'(sb_e.is_wr), 32'd1);
            chk("sb_wr_addr", 32'(mem_addr), 32'(sb_e.addr));
            chk("sb_wr_data", mem_wdata, sb_e.data);
          end
        end else begin
          rd_accepts++;
          rd_addr      = mem_addr;
          last_rd_addr = mem_addr;
          if (rdv_delay == 0) begin
            mem_readdatavalid = 1'b1;
            mem_readdata      = sram[mem_addr];
          end else begin
            rdv_cnt = rdv_delay;
          end
        end
      end
    end else begin
      in_req          = 1'b0;
      mem_waitrequest = 1'b0;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Pulse lands in cycle N; returns shortly after the negedge of cycle N+1.
  task automatic cmd(input bit a, input bit b, input bit n, input logic [37:0] d);
    @(negedge clk);
    jdo                     = d;
    take_action_ocimem_a    = a;
    take_action_ocimem_b    = b;
    take_no_action_ocimem_a = n;
    @(negedge clk);
    jdo                     = '0;
    take_action_ocimem_a    = 1'b0;
    take_action_ocimem_b    = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    #1;
  endtask

  task automatic wait_ready(input string tag, output int waited);
    waited = 0;
    while (!monitor_ready && waited < 50) begin
      step();
      waited++;
    end
    if (!monitor_ready) chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic check_read(input string tag);
    exp_t e;
    if (exp_q.size() == 0) chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    else begin
      e = exp_q.pop_front();
      chk({tag, "_kind"}, 32'(e.is_wr), 32'd0);
      chk({tag, "_addr"}, 32'(last_rd_addr), 32'(e.addr));
      chk({tag, "_data"}, MonDReg, e.data);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int base;
    logic [31:0] keep_data;

    for (int i = 0; i < 256; i++) begin
      sram[i]    = 32'hC0DE_0000 + 32'(i * 3);
      ref_mem[i] = 32'hC0DE_0000 + 32'(i * 3);
    end
    reset                   = 1'b1;
    jdo                     = '0;
    take_action_ocimem_a    = 1'b0;
    take_action_ocimem_b    = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    repeat (3) step();
    chk("rst_mem_read", 32'(mem_read), 32'd0);
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_mondreg", MonDReg, 32'd0);
    chk("rst_ready", 32'(monitor_ready), 32'd0);
    chk("rst_error", 32'(monitor_error), 32'd0);
    reset = 1'b0;
    step();

    // address load without read
    cmd(1'b1, 1'b0, 1'b0, 38'h0_0000_0010);
    chk("t1_ready", 32'(monitor_ready), 32'd1);
    chk("t1_error", 32'(monitor_error), 32'd0);
    chk("t1_no_read", 32'(mem_read), 32'd0);
    chk("t1_addr", 32'(mem_addr), 32'h10);

    // write with three stall cycles
    wait_cycles = 3;
    wr_cycles   = 0;
    unstable    = 0;
    exp_q.push_back('{1'b1, 8'h10, 32'hDEADBEEF});
    ref_mem[8'h10] = 32'hDEADBEEF;
    cmd(1'b0, 1'b1, 1'b0, {6'h0, 32'hDEADBEEF});
    chk("t2_busy", 32'(monitor_ready), 32'd0);
    chk("t2_wr_addr", 32'(mem_addr), 32'h10);
    wait_ready("t2", w);
    chk("t2_latency", 32'(w), 32'd4);
    chk("t2_wr_cycles", 32'(wr_cycles), 32'd4);
    chk("t2_stable", 32'(unstable), 32'd0);
    chk("t2_addr_inc", 32'(mem_addr), 32'h11);
    chk("t2_error", 32'(monitor_error), 32'd0);
    wait_cycles = 0;

    // load plus read, zero-wait slave, data one cycle after acceptance
    exp_q.push_back('{1'b0, 8'h10, ref_mem[8'h10]});
    cmd(1'b1, 1'b0, 1'b0, 38'h8_0000_0010);
    chk("t3_rd_req", 32'(mem_read), 32'd1);
    chk("t3_rd_addr", 32'(mem_addr), 32'h10);
    wait_ready("t3", w);
    chk("t3_latency", 32'(w), 32'd2);
    check_read("t3");
    chk("t3_addr_inc", 32'(mem_addr), 32'h11);

    // plain read at the incremented address
    exp_q.push_back('{1'b0, 8'h11, ref_mem[8'h11]});
    cmd(1'b0, 1'b0, 1'b1, 38'h0);
    wait_ready("t3b", w);
    check_read("t3b");
    chk("t3b_addr_inc", 32'(mem_addr), 32'h12);

    // wrap at the top of the address space
    cmd(1'b1, 1'b0, 1'b0, 38'h0_0000_00FF);
    chk("t4_load", 32'(mem_addr), 32'hFF);
    exp_q.push_back('{1'b0, 8'hFF, ref_mem[8'hFF]});
    cmd(1'b0, 1'b0, 1'b1, 38'h0);
    wait_ready("t4", w);
    check_read("t4");
    chk("t4_wrap", 32'(mem_addr), 32'h00);
    chk("t4_error", 32'(monitor_error), 32'd0);

    // readdatavalid in the acceptance cycle
    rdv_delay = 0;
    exp_q.push_back('{1'b0, 8'h00, ref_mem[8'h00]});
    cmd(1'b0, 1'b0, 1'b1, 38'h0);
    wait_ready("t4b", w);
    chk("t4b_latency", 32'(w), 32'd1);
    check_read("t4b");
    chk("t4b_addr_inc", 32'(mem_addr), 32'h01);
    rdv_delay = 1;
    keep_data = ref_mem[8'h00];

    // timeout with waitrequest stuck high
    stuck     = 1'b1;
    rd_cycles = 0;
    cmd(1'b0, 1'b0, 1'b1, 38'h0);
    wait_ready("t5", w);
    chk("t5_latency", 32'(w), 32'd4);
    chk("t5_rd_cycles", 32'(rd_cycles), 32'd4);
    chk("t5_read_off", 32'(mem_read), 32'd0);
    chk("t5_error", 32'(monitor_error), 32'd1);
    chk("t5_addr_kept", 32'(mem_addr), 32'h01);
    chk("t5_mondreg_kept", MonDReg, keep_data);
    stuck = 1'b0;
    cmd(1'b1, 1'b0, 1'b0, 38'h0_0000_0020);
    chk("t5_err_clear", 32'(monitor_error), 32'd0);
    chk("t5_load", 32'(mem_addr), 32'h20);

    // read data returning after a timeout is ignored
    rdv_delay = 6;
    cmd(1'b0, 1'b0, 1'b1, 38'h0);
    wait_ready("t5b", w);
    chk("t5b_error", 32'(monitor_error), 32'd1);
    repeat (4) step();
    chk("t5b_mondreg_kept", MonDReg, keep_data);
    chk("t5b_addr_kept", 32'(mem_addr), 32'h20);
    rdv_delay = 1;
    cmd(1'b1, 1'b0, 1'b0, 38'h0_0000_0020);
    chk("t5b_err_clear", 32'(monitor_error), 32'd0);

    // overrun: read command during RD_WAIT
    rdv_delay = 3;
    base      = rd_accepts;
    exp_q.push_back('{1'b0, 8'h20, ref_mem[8'h20]});
    cmd(1'b0, 1'b0, 1'b1, 38'h0);
    cmd(1'b0, 1'b0, 1'b1, 38'h0);
    wait_ready("t6a", w);
    check_read("t6a");
    chk("t6a_error", 32'(monitor_error), 32'd1);
    chk("t6a_addr_inc", 32'(mem_addr), 32'h21);
    repeat (3) step();
    chk("t6a_one_read", 32'(rd_accepts - base), 32'd1);
    chk("t6a_idle", 32'(mem_read), 32'd0);
    rdv_delay = 1;

    // simultaneous address load and write
    cmd(1'b1, 1'b0, 1'b0, 38'h0_0000_0030);
    chk("t6b_err_clear", 32'(monitor_error), 32'd0);
    base = wr_accepts;
    cmd(1'b1, 1'b1, 1'b0, 38'h0_1234_5640);
    chk("t6b_addr", 32'(mem_addr), 32'h40);
    chk("t6b_error", 32'(monitor_error), 32'd1);
    chk("t6b_ready", 32'(monitor_ready), 32'd1);
    chk("t6b_no_write", 32'(mem_write), 32'd0);
    repeat (3) step();
    chk("t6b_no_write_acc", 32'(wr_accepts - base), 32'd0);

    // reset in the middle of a stalled read
    stuck = 1'b1;
    cmd(1'b0, 1'b0, 1'b1, 38'h0);
    chk("t7_read_on", 32'(mem_read), 32'd1);
    step();
    reset = 1'b1;
    #1;
    chk("t7_read_off", 32'(mem_read), 32'd0);
    chk("t7_addr", 32'(mem_addr), 32'd0);
    chk("t7_mondreg", MonDReg, 32'd0);
    chk("t7_ready", 32'(monitor_ready), 32'd0);
    chk("t7_error", 32'(monitor_error), 32'd0);
    stuck = 1'b0;
    step();
    reset = 1'b0;
    step();

    // write then read back after reset
    cmd(1'b1, 1'b0, 1'b0, 38'h0_0000_0005);
    exp_q.push_back('{1'b1, 8'h05, 32'hA5A5_0F0F});
    ref_mem[8'h05] = 32'hA5A5_0F0F;
    cmd(1'b0, 1'b1, 1'b0, {6'h0, 32'hA5A5_0F0F});
    wait_ready("t8w", w);
    chk("t8w_addr_inc", 32'(mem_addr), 32'h06);
    exp_q.push_back('{1'b0, 8'h05, ref_mem[8'h05]});
    cmd(1'b1, 1'b0, 1'b0, 38'h8_0000_0005);
    wait_ready("t8r", w);
    check_read("t8r");

    chk("never_both", 32'(both_cnt), 32'd0);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/jtag_debug_ocimem_access.md
Name: jtag_debug_ocimem_access

Overview:
- Executes debug-memory commands in the sysclk domain, directly downstream of the JTAG debug-slave wrapper.
- Consumes the wrapper's jdo bus and the take_action_ocimem_a, take_action_ocimem_b and take_no_action_ocimem_a pulses.
- Runs single-word read/write transactions on a debug RAM master port with a waitrequest/readdatavalid handshake.
- Returns MonDReg, monitor_ready and monitor_error, which the JTAG side scans back to the host.

Parameters:
ADDR_W, 8, word-address width of debug RAM (256 words)
TIMEOUT, 255, max cycles a transaction may stall before abort (1..65535)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous active-high reset
jdo  input  38  command payload from debug slave, valid in pulse cycle
take_action_ocimem_a  input  1  1-cycle pulse: address load command
take_action_ocimem_b  input  1  1-cycle pulse: write command
take_no_action_ocimem_a  input  1  1-cycle pulse: read command
mem_addr  output  ADDR_W  debug RAM word address
mem_read  output  1  read request, held until accepted
mem_write  output  1  write request, held until accepted
mem_wdata  output  32  write data
mem_waitrequest  input  1  slave stall; request accepted in a cycle with waitrequest=0
mem_readdata  input  32  read data
mem_readdatavalid  input  1  read data valid, any cycle after acceptance
MonDReg  output  32  last read data
monitor_ready  output  1  last command completed, MonDReg valid
monitor_error  output  1  sticky error: timeout or overrun

Behaviour:
- Reset (async, active-high) values:
  - State=IDLE; addr=0; mem_read=mem_write=0; mem_wdata=0; MonDReg=0; monitor_ready=0; monitor_error=0; timeout counter=0.
- FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ.
- Commands are sampled only in IDLE.
- Priority within one cycle: ocimem_a > ocimem_b > no_action_a. Lower-priority pulses in the same cycle are dropped and set monitor_error.
- take_action_ocimem_a (address load):
  - addr <= jdo[ADDR_W-1:0].
  - If jdo[35]=1, go to RD_REQ (load plus read); otherwise stay IDLE.
  - Clears monitor_error, except when that same cycle also drops a lower-priority pulse; the drop sets it.
  - monitor_ready=1 the next cycle when jdo[35]=0.
- take_action_ocimem_b (write): mem_wdata <= jdo[31:0]; go to WR_REQ.
- take_no_action_ocimem_a (read): go to RD_REQ.
- monitor_ready:
  - Cleared the cycle after any command other than an address load with jdo[35]=0.
  - Set the cycle after completion.
- RD_REQ:
  - mem_read=1, mem_addr=addr.
  - On waitrequest=0: drop mem_read next cycle, go to RD_WAIT.
  - If readdatavalid arrives in the same acceptance cycle, complete immediately.
- RD_WAIT: on readdatavalid, MonDReg <= mem_readdata, addr <= addr+1, go to IDLE, monitor_ready=1.
- WR_REQ:
  - mem_write=1, mem_addr=addr, mem_wdata held.
  - On waitrequest=0: addr <= addr+1, go to IDLE, monitor_ready=1.
- Address auto-increment: modulo 2^ADDR_W; from all-ones it wraps to 0 with no error.
- Latency with zero-wait slave and readdatavalid one cycle after acceptance:
  - Read: pulse at cycle N, mem_read asserted N+1, data captured N+2, monitor_ready=1 at N+3.
  - Write: pulse N, mem_write N+1, monitor_ready N+2.
- Timeout:
  - Counter clears on entering any non-IDLE state and increments each non-IDLE cycle.
  - On reaching TIMEOUT: deassert request, monitor_error=1, monitor_ready=1, go to IDLE.
  - addr is not incremented and MonDReg is unchanged.
- Overrun: any command pulse while not in IDLE is ignored and sets monitor_error; the in-flight transaction continues.
- Late data: a readdatavalid arriving in IDLE after a timeout is ignored and MonDReg is not updated.
- Reset mid-transaction: request deasserts immediately (async); no partial state is retained.
- mem_read and mem_write are never asserted together.
- mem_addr and mem_wdata stay stable while a request is held under waitrequest.

Test Plan:
1. Reset then ocimem_a with jdo=0x0_0000_0010, jdo[35]=0 -> addr=0x10, no mem_read, monitor_ready=1 next cycle, monitor_error=0.
2. ocimem_b with jdo[31:0]=0xDEADBEEF, waitrequest held 3 cycles -> mem_write=1 for 4 cycles at addr 0x10, mem_wdata stable, then addr=0x11, monitor_ready=1.
3. ocimem_a addr=0x10 with jdo[35]=1, slave returns 0xDEADBEEF -> MonDReg=0xDEADBEEF, monitor_ready=1 at N+3, addr=0x11.
4. Load addr=0xFF, then read -> mem_addr=0xFF, afterwards addr=0x00.
5. TIMEOUT=4, read with waitrequest stuck 1 -> mem_read drops after 4 cycles, monitor_error=1, monitor_ready=1, addr and MonDReg unchanged. Next ocimem_a clears monitor_error.
6. Fire no_action_a while in RD_WAIT, and separately assert ocimem_a and ocimem_b in the same cycle -> in-flight read still completes and monitor_error=1. For the simultaneous pair, address load executes, no write occurs, monitor_error=1.
